// File: rtl/sc_level_cmd_gen_pkg.sv
// Shared definitions for the level-counter command generator.
// Contents: the command bus encodings, the FSM state type and the default
// level/goal parameters that the top and the testbench use.
package sc_level_cmd_gen_pkg;

    localparam logic [2:0] CMD_INC  = 3'b000;   // counter increments
    localparam logic [2:0] CMD_HOLD = 3'b111;   // counter holds; any other value loads

    localparam int LEVEL_START_DEF = 1;
    localparam int LEVEL_MAX_DEF   = 6;         // 7 cannot be loaded: it encodes hold
    localparam int GOAL_COUNT_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // bus holds, events evaluated
        ST_ISSUE  = 2'd1,   // command on the bus for exactly one cycle
        ST_SETTLE = 2'd2,   // bus holds while the counter's level updates
        ST_WIN    = 2'd3    // top level finished; only game over / select leave
    } state_t;

endpackage

// File: rtl/sc_level_cmd_gen_if.sv
// Event/command bus of the level-counter command generator.
// Signals:
//   SC_LEVELCMD_GOAL_InHigh     - frog-in-goal level; rising edge = one arrival
//   SC_LEVELCMD_GAMEOVER_InHigh - game-over level; rising edge acts
//   SC_LEVELCMD_LOAD_InLow      - level-select button; falling edge acts
//   SC_LEVELCMD_SELECT_InBUS    - requested level for a select load
//   SC_LEVELCMD_LEVEL_InBUS     - level fed back from the level counter
//   SC_LEVELCMD_CUENTA_OutLow   - command bus (000 inc, 111 hold, else load)
//   SC_LEVELCMD_GOALS_OutBUS    - arrivals counted in the current level
//   SC_LEVELCMD_WIN_OutHigh     - sticky win flag
// Modports: master drives the events, slave is the command generator.
interface sc_level_cmd_gen_if #(parameter int DATAWIDTH_3 = 3);

    logic                   SC_LEVELCMD_GOAL_InHigh;
    logic                   SC_LEVELCMD_GAMEOVER_InHigh;
    logic                   SC_LEVELCMD_LOAD_InLow;
    logic [DATAWIDTH_3-1:0] SC_LEVELCMD_SELECT_InBUS;
    logic [DATAWIDTH_3-1:0] SC_LEVELCMD_LEVEL_InBUS;
    logic [DATAWIDTH_3-1:0] SC_LEVELCMD_CUENTA_OutLow;
    logic [1:0]             SC_LEVELCMD_GOALS_OutBUS;
    logic                   SC_LEVELCMD_WIN_OutHigh;

    modport master (
        output SC_LEVELCMD_GOAL_InHigh, SC_LEVELCMD_GAMEOVER_InHigh, SC_LEVELCMD_LOAD_InLow,
               SC_LEVELCMD_SELECT_InBUS, SC_LEVELCMD_LEVEL_InBUS,
        input  SC_LEVELCMD_CUENTA_OutLow, SC_LEVELCMD_GOALS_OutBUS, SC_LEVELCMD_WIN_OutHigh
    );

    modport slave (
        input  SC_LEVELCMD_GOAL_InHigh, SC_LEVELCMD_GAMEOVER_InHigh, SC_LEVELCMD_LOAD_InLow,
               SC_LEVELCMD_SELECT_InBUS, SC_LEVELCMD_LEVEL_InBUS,
        output SC_LEVELCMD_CUENTA_OutLow, SC_LEVELCMD_GOALS_OutBUS, SC_LEVELCMD_WIN_OutHigh
    );

endinterface

// File: rtl/sc_level_cmd_gen_edge.sv
// sc_edge_detect: single-cycle pulse on the active edge of a level input.
// Ports: clk, rst_n (async, active low), din (level input), pulse (edge seen
// this cycle, combinational from the registered history).
// RISE=1 detects 0->1, RISE=0 detects 1->0. IDLE_VAL is the inactive level the
// history resets to, so a signal sitting idle out of reset never fires.
// Macro SC_LEVELCMD_SYNC_EN: adds a 2-flop synchronizer ahead of the detector.
module sc_edge_detect #(
    parameter bit RISE     = 1'b1,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic s;
    logic prev;

`ifdef SC_LEVELCMD_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{IDLE_VAL}};
        else        sync_q <= {sync_q[0], din};
    end
    assign s = sync_q[1];
`else
    assign s = din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= IDLE_VAL;
        else        prev <= s;
    end

    assign pulse = RISE ? (s & ~prev) : (~s & prev);

endmodule

// File: rtl/sc_level_cmd_gen.sv
// sc_level_cmd_gen: turns game events into commands for the level counter.
// Ports: SC_LEVELCMD_CLOCK_50 (clock), SC_LEVELCMD_RESET_InLow (async reset,
// active low), bus (sc_level_cmd_gen_if.slave: event inputs, level feedback,
// command / goal count / win outputs). All outputs are registered.
// Macro SC_LEVELCMD_SYNC_EN: synchronize the event inputs (+2 cycles latency).
module sc_level_cmd_gen
    import sc_level_cmd_gen_pkg::*;
#(
    parameter int DATAWIDTH_3 = 3,
    parameter int LEVEL_START = LEVEL_START_DEF,
    parameter int LEVEL_MAX   = LEVEL_MAX_DEF,
    parameter int GOAL_COUNT  = GOAL_COUNT_DEF
) (
    input logic             SC_LEVELCMD_CLOCK_50,
    input logic             SC_LEVELCMD_RESET_InLow,
    sc_level_cmd_gen_if.slave bus
);

    localparam logic [DATAWIDTH_3-1:0] LV_START = LEVEL_START[DATAWIDTH_3-1:0];
    localparam logic [DATAWIDTH_3-1:0] LV_MAX   = LEVEL_MAX[DATAWIDTH_3-1:0];
    localparam logic [1:0]             GOAL_N   = GOAL_COUNT[1:0];

    logic goal_edge, go_edge, ld_edge;

    sc_edge_detect #(.RISE(1'b1), .IDLE_VAL(1'b0)) u_goal (
        .clk(SC_LEVELCMD_CLOCK_50), .rst_n(SC_LEVELCMD_RESET_InLow),
        .din(bus.SC_LEVELCMD_GOAL_InHigh), .pulse(goal_edge));
    sc_edge_detect #(.RISE(1'b1), .IDLE_VAL(1'b0)) u_gameover (
        .clk(SC_LEVELCMD_CLOCK_50), .rst_n(SC_LEVELCMD_RESET_InLow),
        .din(bus.SC_LEVELCMD_GAMEOVER_InHigh), .pulse(go_edge));
    sc_edge_detect #(.RISE(1'b0), .IDLE_VAL(1'b1)) u_load (
        .clk(SC_LEVELCMD_CLOCK_50), .rst_n(SC_LEVELCMD_RESET_InLow),
        .din(bus.SC_LEVELCMD_LOAD_InLow), .pulse(ld_edge));

    state_t                 state_q, state_d;
    logic [DATAWIDTH_3-1:0] cuenta_q, cuenta_d;
    logic [1:0]             goals_q, goals_d, goals_inc;
    logic                   win_q, win_d;
    // Events arriving while a command is in flight wait here (1-deep each).
    logic                   pgo_q, pgo_d, psel_q, psel_d, pgoal_q, pgoal_d;
    logic [DATAWIDTH_3-1:0] pval_q, pval_d;

    logic [DATAWIDTH_3-1:0] sel_clamp, sel_val, lvl_in, lvl_eff;
    logic                   ev_go, ev_sel, ev_goal;

    assign lvl_in    = bus.SC_LEVELCMD_LEVEL_InBUS;
    // 0 and 7 are not legal levels; treat them as the top so nothing increments.
    assign lvl_eff   = (lvl_in == '0 || lvl_in == '1) ? LV_MAX : lvl_in;
    assign sel_clamp = (bus.SC_LEVELCMD_SELECT_InBUS == '0)    ? LV_START :
                       (bus.SC_LEVELCMD_SELECT_InBUS > LV_MAX) ? LV_MAX   :
                       bus.SC_LEVELCMD_SELECT_InBUS;

    always_ff @(posedge SC_LEVELCMD_CLOCK_50 or negedge SC_LEVELCMD_RESET_InLow) begin
        if (!SC_LEVELCMD_RESET_InLow) begin
            state_q  <= ST_IDLE;
            cuenta_q <= CMD_HOLD;
            goals_q  <= '0;
            win_q    <= 1'b0;
            pgo_q    <= 1'b0;
            psel_q   <= 1'b0;
            pgoal_q  <= 1'b0;
            pval_q   <= '0;
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            goals_q  <= goals_d;
            win_q    <= win_d;
            pgo_q    <= pgo_d;
            psel_q   <= psel_d;
            pgoal_q  <= pgoal_d;
            pval_q   <= pval_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cuenta_d  = CMD_HOLD;
        goals_d   = goals_q;
        win_d     = win_q;
        pgo_d     = pgo_q;
        psel_d    = psel_q;
        pgoal_d   = pgoal_q;
        pval_d    = pval_q;
        // Pending flags are only ever set outside IDLE/WIN, and are consumed
        // (or superseded) on the first IDLE cycle, as if the edge were fresh.
        ev_go     = go_edge | pgo_q;
        ev_sel    = ld_edge | psel_q;
        ev_goal   = goal_edge | pgoal_q;
        sel_val   = ld_edge ? sel_clamp : pval_q;
        goals_inc = goals_q + 2'd1;
        case (state_q)
            ST_IDLE, ST_WIN: begin
                pgo_d   = 1'b0;
                psel_d  = 1'b0;
                pgoal_d = 1'b0;
                if (ev_go) begin
                    cuenta_d = LV_START;
                    goals_d  = '0;
                    win_d    = 1'b0;
                    state_d  = ST_ISSUE;
                end else if (ev_sel) begin
                    cuenta_d = sel_val;
                    goals_d  = '0;
                    win_d    = 1'b0;
                    state_d  = ST_ISSUE;
                end else if (ev_goal && state_q == ST_IDLE) begin
                    if (goals_inc == GOAL_N) begin
                        goals_d = '0;
                        if (lvl_eff < LV_MAX) begin
                            cuenta_d = CMD_INC;
                            state_d  = ST_ISSUE;
                        end else begin
                            win_d   = 1'b1;
                            state_d = ST_WIN;
                        end
                    end else begin
                        goals_d = goals_inc;
                    end
                end
            end
            default: begin
                state_d = (state_q == ST_ISSUE) ? ST_SETTLE : ST_IDLE;
                if (go_edge)   pgo_d   = 1'b1;
                if (goal_edge) pgoal_d = 1'b1;
                if (ld_edge && !psel_q) begin
                    psel_d = 1'b1;
                    pval_d = sel_clamp;
                end
            end
        endcase
    end

    assign bus.SC_LEVELCMD_CUENTA_OutLow = cuenta_q;
    assign bus.SC_LEVELCMD_GOALS_OutBUS  = goals_q;
    assign bus.SC_LEVELCMD_WIN_OutHigh   = win_q;

endmodule

// File: tb/tb_sc_level_cmd_gen.sv
// Self-checking bench for sc_level_cmd_gen: directed scenarios followed by
// random single events, all checked against a rule-level model of the game.
module tb_sc_level_cmd_gen;

`ifdef SC_LEVELCMD_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // model state
    int   m_goals = 0;
    logic m_win   = 1'b0;

    always #5 clk = ~clk;

    sc_level_cmd_gen_if bus ();

    sc_level_cmd_gen dut (
        .SC_LEVELCMD_CLOCK_50   (clk),
        .SC_LEVELCMD_RESET_InLow(rst_n),
        .bus                    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mask: bit0 goal rise, bit1 game-over rise, bit2 select (LOAD fall).
    task automatic do_event(input logic [2:0] mask, input logic [2:0] sel, input logic [2:0] lvl);
        int       exp_cmd;
        int       ng;
        logic     nw;
        int       le;
        exp_cmd = -1;
        ng      = m_goals;
        nw      = m_win;
        if (mask[1]) begin
            exp_cmd = 1; ng = 0; nw = 1'b0;
        end else if (mask[2]) begin
            exp_cmd = (sel == 0) ? 1 : ((sel > 6) ? 6 : int'(sel));
            ng = 0; nw = 1'b0;
        end else if (mask[0] && !m_win) begin
            le = (lvl == 0 || lvl == 7) ? 6 : int'(lvl);
            if (m_goals + 1 == 3) begin
                ng = 0;
                if (le < 6) exp_cmd = 0;
                else        nw = 1'b1;
            end else begin
                ng = m_goals + 1;
            end
        end
        bus.SC_LEVELCMD_LEVEL_InBUS  = lvl;
        bus.SC_LEVELCMD_SELECT_InBUS = sel;
        if (mask[0]) bus.SC_LEVELCMD_GOAL_InHigh     = 1'b1;
        if (mask[1]) bus.SC_LEVELCMD_GAMEOVER_InHigh = 1'b1;
        if (mask[2]) bus.SC_LEVELCMD_LOAD_InLow      = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) begin
                bus.SC_LEVELCMD_GOAL_InHigh     = 1'b0;
                bus.SC_LEVELCMD_GAMEOVER_InHigh = 1'b0;
                bus.SC_LEVELCMD_LOAD_InLow      = 1'b1;
            end
            check("cuenta", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow},
                  (c == LAT && exp_cmd >= 0) ? 8'(exp_cmd) : 8'd7);
            check("goals", {6'd0, bus.SC_LEVELCMD_GOALS_OutBUS}, (c < LAT) ? 8'(m_goals) : 8'(ng));
            check("win", {7'd0, bus.SC_LEVELCMD_WIN_OutHigh}, (c < LAT) ? {7'd0, m_win} : {7'd0, nw});
        end
        m_goals = ng;
        m_win   = nw;
    endtask

    initial begin
        bus.SC_LEVELCMD_GOAL_InHigh     = 1'b0;
        bus.SC_LEVELCMD_GAMEOVER_InHigh = 1'b0;
        bus.SC_LEVELCMD_LOAD_InLow      = 1'b1;
        bus.SC_LEVELCMD_SELECT_InBUS    = 3'd0;
        bus.SC_LEVELCMD_LEVEL_InBUS     = 3'd1;
        tick(); tick();
        check("rst_cuenta", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd7);
        check("rst_goals", {6'd0, bus.SC_LEVELCMD_GOALS_OutBUS}, 8'd0);
        check("rst_win", {7'd0, bus.SC_LEVELCMD_WIN_OutHigh}, 8'd0);
        rst_n = 1'b1;
        tick(); tick();

        // three arrivals at level 1: 1, 2, then increment
        repeat (3) do_event(3'b001, 3'd0, 3'd1);
        // three arrivals at the top level: win, no increment; a 4th is ignored
        repeat (4) do_event(3'b001, 3'd0, 3'd6);
        // game over leaves WIN
        do_event(3'b010, 3'd0, 3'd6);
        // select clamping
        do_event(3'b100, 3'd7, 3'd1);
        do_event(3'b100, 3'd0, 3'd6);
        do_event(3'b100, 3'd4, 3'd1);
        // game over and goal together: only the load
        do_event(3'b001, 3'd0, 3'd1);
        do_event(3'b011, 3'd0, 3'd1);

        // goal edge during SETTLE is held and counted on return to IDLE
        bus.SC_LEVELCMD_LEVEL_InBUS  = 3'd1;
        bus.SC_LEVELCMD_SELECT_InBUS = 3'd2;
        bus.SC_LEVELCMD_LOAD_InLow   = 1'b0;
        repeat (LAT) tick();
        check("settle_cmd", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd2);
        bus.SC_LEVELCMD_LOAD_InLow = 1'b1;
        tick();
        check("settle_hold", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd7);
        bus.SC_LEVELCMD_GOAL_InHigh = 1'b1;
        repeat (LAT + 1) tick();
        check("settle_goals", {6'd0, bus.SC_LEVELCMD_GOALS_OutBUS}, 8'd1);
        check("settle_nocmd", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd7);
        bus.SC_LEVELCMD_GOAL_InHigh = 1'b0;
        repeat (4) tick();
        m_goals = 1;
        m_win   = 1'b0;

        // reset while the increment is on the bus
        do_event(3'b001, 3'd0, 3'd1);
        bus.SC_LEVELCMD_GOAL_InHigh = 1'b1;
        repeat (LAT) tick();
        check("issue_inc", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_cuenta", {5'd0, bus.SC_LEVELCMD_CUENTA_OutLow}, 8'd7);
        check("async_goals", {6'd0, bus.SC_LEVELCMD_GOALS_OutBUS}, 8'd0);
        check("async_win", {7'd0, bus.SC_LEVELCMD_WIN_OutHigh}, 8'd0);
        bus.SC_LEVELCMD_GOAL_InHigh = 1'b0;
        tick(); tick();
        rst_n   = 1'b1;
        m_goals = 0;
        m_win   = 1'b0;
        tick(); tick();

        // random isolated events
        for (int i = 0; i < 40; i++) begin
            logic [2:0] mask, sel, lvl;
            mask = 3'($urandom_range(1, 7));
            sel  = 3'($urandom_range(0, 7));
            lvl  = 3'($urandom_range(0, 7));
            do_event(mask, sel, lvl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
